apb_arbiter: RTL and testbench
==============================

Name: apb_arbiter

Overview:
- Multi-requester APB requester-side controller that shares one APB peripheral bus among NUM_REQ local requesters.
- Arbitrates round-robin, captures the winning command, and sequences the APB SETUP/ACCESS phases.
- Returns read data and error status to the granted requester.
- Sits between on-chip initiators and the apb_if requester modport feeding apb_peripheral instances.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
TIMEOUT, 16, max ACCESS cycles without pready before abort (used only with APB_ARB_TIMEOUT_EN)

Ports:
pclk  in  1  APB clock
presetn  in  1  async active-low reset
req  in  NUM_REQ  per-requester transfer request, level, held until done
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, slice i = requester i
req_write  in  NUM_REQ  1=write
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_strb  in  NUM_REQ*STRB_WIDTH  flattened byte strobes
req_prot  in  NUM_REQ*3  flattened pprot
gnt  out  NUM_REQ  one-hot, high during the SETUP cycle of granted transfer
done  out  NUM_REQ  one-hot 1-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data of last completed transfer
rsp_err  out  1  pslverr (or timeout) of last completed transfer
psel, penable, pwrite  out  1  APB control
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  STRB_WIDTH  APB strobes (forced 0 on reads)
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pready, pslverr  in  1  APB completion/error

Behaviour:
- Clock pclk; reset presetn is asynchronous, active-low.
- Reset: state ARB_IDLE, rr pointer 0, all outputs 0 (psel, penable, gnt, done, rsp_rdata, rsp_err, paddr, pwdata, pstrb, pprot, pwrite). Reset mid-transfer aborts silently; no done is issued.
- FSM states:
  - ARB_IDLE: if any req, arbitrate, latch winner command into registered APB outputs, go to ARB_SETUP at next edge. Otherwise stay; psel=0.
  - ARB_SETUP: psel=1, penable=0, gnt[winner]=1; always go to ARB_ACCESS.
  - ARB_ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb/pprot stable. pready=0: stay. pready=1: capture prdata (reads only; writes leave rsp_rdata unchanged) and pslverr into rsp_rdata/rsp_err, then pulse done[winner] next cycle. On the same edge, re-arbitrate excluding the finishing requester: any other req goes straight to ARB_SETUP (back-to-back, psel stays high, penable drops); none goes to ARB_IDLE.
- Arbitration: round-robin starting at rr pointer. After a grant, the pointer becomes winner+1 mod NUM_REQ. The finishing requester may win again only if it is the sole requester and is sampled after its done cycle.
- Requester contract: deassert req in the done cycle or later; command fields are sampled only at the grant edge. Changes afterward are ignored.
- Latency, zero wait states: req seen at edge 0, SETUP cycle 1, ACCESS cycle 2 (pready=1), done cycle 3. Each peripheral wait state adds 1 cycle.
- pready/pslverr/prdata are ignored outside ARB_ACCESS.
- NUM_REQ=1: pointer constant 0, behaviour otherwise identical.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined: a counter (clog2(TIMEOUT+1) bits) clears on entering ARB_ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT, the transfer ends as if pready=1 with pslverr=1, except rsp_rdata=0. Normal arbitration follows.
- Undefined: no counter; ARB_ACCESS waits indefinitely for pready.

Decomposition:
- apb_pkg: ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH (existing); add typedef enum arb_state_t {ARB_IDLE, ARB_SETUP, ARB_ACCESS}.
- Sub-module rr_arbiter (combinational round-robin pick from req mask + pointer, outputs one-hot grant and valid). The FSM stays in apb_arbiter.

Test Plan:
- Single read, req[0], addr 0x04, peripheral numWS=0 -> SETUP cycle 1, ACCESS cycle 2, done[0] cycle 3, rsp_rdata = stored word, rsp_err=0.
- Write req[2], addr 0x08, wdata 0xDEADBEEF, strb 4'hF, then read-back -> pstrb=0 on read, rsp_rdata=0xDEADBEEF.
- req[0..3] all asserted at once, held until done -> grants in order 0,1,2,3 with back-to-back transfers; psel never drops; penable=0 exactly 1 cycle between.
- Misaligned addr 0x01 -> pslverr sampled, done pulses with rsp_err=1; next requester still served.
- numWS=3 -> ACCESS lasts 4 cycles, done at cycle 6; with APB_ARB_TIMEOUT_EN and TIMEOUT=2, a non-responding peripheral -> done after 2 ACCESS cycles, rsp_err=1, rsp_rdata=0.
- presetn asserted during ACCESS -> all outputs 0 immediately; after release, pending req restarts from pointer 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB bus widths and the arbiter FSM state encoding.
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } arb_state_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; master modport for the requester side, slave modport for peripherals.
interface apb_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of i_mask at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_mask[w_pos]) begin
        o_valid       = 1'b1;
        o_gnt[w_pos]  = 1'b1;
        o_idx         = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB bus among NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  input  logic [NUM_REQ*3-1:0]             req_prot,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  apb_if.master                            apb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t            r_state, w_next;
  logic [NUM_REQ-1:0]    w_mask, w_arb_gnt, r_winner, r_done;
  logic [PTR_W-1:0]      w_arb_idx, r_ptr;
  logic                  w_arb_valid, w_grant, w_xfer_end, w_timeout;
  logic                  w_psel, w_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [2:0]            r_pprot;
  logic                  r_rsp_err;

  // The finishing/just-finished requester is masked so it cannot win before its done cycle is over.
  always_comb begin
    w_mask = '0;
    if (r_state == ARB_IDLE)
      w_mask = req & ~r_done;
    else if (r_state == ARB_ACCESS)
      w_mask = req & ~r_winner;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_xfer_end = (r_state == ARB_ACCESS) && (apb.pready || w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      r_tmo_cnt <= '0;
    else if (r_state == ARB_SETUP)
      r_tmo_cnt <= '0;
    else if (r_state == ARB_ACCESS && !apb.pready)
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Fires on the wait cycle that would bring the count to TIMEOUT.
  assign w_timeout = (r_state == ARB_ACCESS) && !apb.pready &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT > 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      r_state <= ARB_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    gnt       = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_arb_valid) begin
          w_grant = 1'b1;
          w_next  = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        w_psel = 1'b1;
        gnt    = r_winner;
        w_next = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (w_xfer_end) begin
          if (w_arb_valid) begin
            w_grant = 1'b1;
            w_next  = ARB_SETUP;
          end else begin
            w_next  = ARB_IDLE;
          end
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_winner    <= '0;
      r_ptr       <= '0;
      r_done      <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_done <= '0;
      if (w_xfer_end) begin
        r_done    <= r_winner;
        r_rsp_err <= apb.pslverr | w_timeout;
        if (w_timeout)
          r_rsp_rdata <= '0;
        else if (!r_pwrite)
          r_rsp_rdata <= apb.prdata;
      end
      if (w_grant) begin
        r_winner <= w_arb_gnt;
        r_ptr    <= (int'(w_arb_idx) == NUM_REQ - 1) ? '0 : w_arb_idx + PTR_W'(1);
        r_paddr  <= req_addr[int'(w_arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        r_pwrite <= req_write[w_arb_idx];
        r_pwdata <= req_wdata[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_pstrb  <= req_write[w_arb_idx] ?
                    req_strb[int'(w_arb_idx)*STRB_WIDTH +: STRB_WIDTH] : '0;
        r_pprot  <= req_prot[int'(w_arb_idx)*3 +: 3];
      end
    end
  end

  assign done        = r_done;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign apb.psel    = w_psel;
  assign apb.penable = w_penable;
  assign apb.pwrite  = r_pwrite;
  assign apb.paddr   = r_paddr;
  assign apb.pwdata  = r_pwdata;
  assign apb.pstrb   = r_pstrb;
  assign apb.pprot   = r_pprot;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter with a small behavioural APB peripheral.
module tb_apb_arbiter;
  import apb_pkg::*;

  localparam int NREQ = 4;

  logic                        pclk = 1'b0;
  logic                        presetn;
  logic [NREQ-1:0]             req;
  logic [NREQ*ADDR_WIDTH-1:0]  reqAddr;
  logic [NREQ-1:0]             reqWrite;
  logic [NREQ*DATA_WIDTH-1:0]  reqWdata;
  logic [NREQ*STRB_WIDTH-1:0]  reqStrb;
  logic [NREQ*3-1:0]           reqProt;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             done;
  logic [DATA_WIDTH-1:0]       rspRdata;
  logic                        rspErr;

  int checkCount = 0;
  int errorCount = 0;

  apb_if bus ();

  apb_arbiter #(
    .NUM_REQ (NREQ),
    .TIMEOUT (2)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_addr  (reqAddr),
    .req_write (reqWrite),
    .req_wdata (reqWdata),
    .req_strb  (reqStrb),
    .req_prot  (reqProt),
    .gnt       (gnt),
    .done      (done),
    .rsp_rdata (rspRdata),
    .rsp_err   (rspErr),
    .apb       (bus)
  );

  always #5 pclk = ~pclk;

  // Behavioural peripheral: numWs wait states, error on misaligned address, noResp stalls forever.
  logic [31:0] mem [0:15];
  int          numWs = 0;
  logic        noResp = 1'b0;
  logic        initMem = 1'b1;
  logic [3:0]  wsCnt;

  assign bus.pready  = bus.psel && bus.penable && !noResp && (wsCnt == 4'(numWs));
  assign bus.prdata  = mem[bus.paddr[5:2]];
  assign bus.pslverr = bus.pready && (bus.paddr[1:0] != 2'b00);

  always @(posedge pclk) begin
    if (initMem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hA0A0_A0A0;
      mem[1] <= 32'h1111_2222;
      mem[2] <= 32'h5555_5555;
      mem[3] <= 32'h3333_4444;
      wsCnt  <= '0;
    end else begin
      if (!(bus.psel && bus.penable) || bus.pready)
        wsCnt <= '0;
      else
        wsCnt <= wsCnt + 4'd1;
      if (bus.pready && bus.pwrite && !bus.pslverr)
        for (int b = 0; b < 4; b++)
          if (bus.pstrb[b]) mem[bus.paddr[5:2]][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic on, input logic [31:0] addr,
                               input logic wr, input logic [31:0] wdata, input logic [3:0] strb);
    req[idx]              = on;
    reqAddr[idx*32 +: 32] = addr;
    reqWrite[idx]         = wr;
    reqWdata[idx*32 +: 32] = wdata;
    reqStrb[idx*4 +: 4]   = strb;
    reqProt[idx*3 +: 3]   = 3'(idx);
  endtask

  task automatic nextCycle();
    @(negedge pclk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] rdExp [4];
  logic [3:0]  expGnt, expDone;

  initial begin
    rdExp[0] = 32'hA0A0_A0A0;
    rdExp[1] = 32'h1111_2222;
    rdExp[2] = 32'hDEAD_BEEF;
    rdExp[3] = 32'h3333_4444;
    presetn  = 1'b0;
    req = '0; reqAddr = '0; reqWrite = '0; reqWdata = '0; reqStrb = '0; reqProt = '0;

    // Reset state
    nextCycle();
    checkOutput("rst_psel", bus.psel, 1'b0);
    checkOutput("rst_penable", bus.penable, 1'b0);
    checkOutput("rst_gnt", gnt, 4'h0);
    checkOutput("rst_done", done, 4'h0);
    checkOutput("rst_rdata", rspRdata, 32'h0);
    checkOutput("rst_err", rspErr, 1'b0);
    checkOutput("rst_paddr", bus.paddr, 32'h0);
    checkOutput("rst_pstrb", bus.pstrb, 4'h0);
    nextCycle();
    initMem = 1'b0;
    presetn = 1'b1;
    nextCycle();

    $display("[TB] single read req0 addr 0x04");
    applyStimulus(0, 1'b1, 32'h04, 1'b0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("rd_setup_psel", bus.psel, 1'b1);
    checkOutput("rd_setup_penable", bus.penable, 1'b0);
    checkOutput("rd_setup_gnt", gnt, 4'b0001);
    checkOutput("rd_paddr", bus.paddr, 32'h04);
    checkOutput("rd_pwrite", bus.pwrite, 1'b0);
    nextCycle();
    checkOutput("rd_access_penable", bus.penable, 1'b1);
    checkOutput("rd_access_gnt", gnt, 4'b0000);
    checkOutput("rd_access_done", done, 4'b0000);
    nextCycle();
    checkOutput("rd_done", done, 4'b0001);
    checkOutput("rd_rdata", rspRdata, 32'h1111_2222);
    checkOutput("rd_err", rspErr, 1'b0);
    checkOutput("rd_idle_psel", bus.psel, 1'b0);
    req[0] = 1'b0;
    nextCycle();
    checkOutput("rd_done_pulse", done, 4'b0000);

    $display("[TB] write req2 then read back");
    applyStimulus(2, 1'b1, 32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF);
    nextCycle();
    checkOutput("wr_gnt", gnt, 4'b0100);
    checkOutput("wr_pwrite", bus.pwrite, 1'b1);
    checkOutput("wr_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_pstrb", bus.pstrb, 4'hF);
    checkOutput("wr_pprot", bus.pprot, 3'd2);
    nextCycle();
    nextCycle();
    checkOutput("wr_done", done, 4'b0100);
    checkOutput("wr_rdata_kept", rspRdata, 32'h1111_2222);
    req[2] = 1'b0;
    nextCycle();
    applyStimulus(2, 1'b1, 32'h08, 1'b0, 32'hFFFF_FFFF, 4'hF);
    nextCycle();
    checkOutput("rb_pstrb", bus.pstrb, 4'h0);
    checkOutput("rb_pwrite", bus.pwrite, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rb_done", done, 4'b0100);
    checkOutput("rb_rdata", rspRdata, 32'hDEAD_BEEF);
    req[2] = 1'b0;
    nextCycle();

    $display("[TB] four requesters back-to-back from fresh pointer");
    presetn = 1'b0;
    nextCycle();
    presetn = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 32'(i * 4), 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      expGnt  = ((c % 2) == 1 && c <= 7) ? 4'(1 << ((c - 1) / 2)) : 4'h0;
      expDone = ((c % 2) == 1 && c >= 3) ? 4'(1 << ((c - 3) / 2)) : 4'h0;
      checkOutput("b2b_psel", bus.psel, (c <= 8) ? 1'b1 : 1'b0);
      checkOutput("b2b_penable", bus.penable, (c <= 8 && (c % 2) == 0) ? 1'b1 : 1'b0);
      checkOutput("b2b_gnt", gnt, expGnt);
      checkOutput("b2b_done", done, expDone);
      if (expDone != 4'h0) begin
        checkOutput("b2b_rdata", rspRdata, rdExp[(c - 3) / 2]);
        req[(c - 3) / 2] = 1'b0;
      end
    end

    $display("[TB] misaligned access then next requester");
    applyStimulus(1, 1'b1, 32'h01, 1'b0, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 32'h0C, 1'b0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("mis_gnt", gnt, 4'b0010);
    checkOutput("mis_paddr", bus.paddr, 32'h01);
    nextCycle();
    nextCycle();
    checkOutput("mis_done", done, 4'b0010);
    checkOutput("mis_err", rspErr, 1'b1);
    checkOutput("mis_next_gnt", gnt, 4'b1000);
    req[1] = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("mis_next_done", done, 4'b1000);
    checkOutput("mis_next_err", rspErr, 1'b0);
    checkOutput("mis_next_rdata", rspRdata, 32'h3333_4444);
    req[3] = 1'b0;
    nextCycle();

    $display("[TB] three wait states");
    numWs = 3;
    applyStimulus(0, 1'b1, 32'h04, 1'b0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("ws_setup_gnt", gnt, 4'b0001);
    for (int c = 2; c <= 5; c++) begin
      nextCycle();
      checkOutput("ws_access_penable", bus.penable, 1'b1);
      checkOutput("ws_access_done", done, 4'b0000);
    end
    nextCycle();
    checkOutput("ws_done", done, 4'b0001);
    checkOutput("ws_rdata", rspRdata, 32'h1111_2222);
    req[0] = 1'b0;
    nextCycle();

`ifdef APB_ARB_TIMEOUT_EN
    $display("[TB] timeout on non-responding peripheral");
    numWs  = 0;
    noResp = 1'b1;
    applyStimulus(0, 1'b1, 32'h04, 1'b0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("tmo_not_yet", done, 4'b0000);
    nextCycle();
    checkOutput("tmo_done", done, 4'b0001);
    checkOutput("tmo_err", rspErr, 1'b1);
    checkOutput("tmo_rdata", rspRdata, 32'h0);
    req[0] = 1'b0;
    noResp = 1'b0;
    nextCycle();
`endif

    $display("[TB] reset during ACCESS");
    numWs = 3;
    applyStimulus(2, 1'b1, 32'h08, 1'b0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    checkOutput("ra_in_access", bus.penable, 1'b1);
    presetn = 1'b0;
    #1;
    checkOutput("ra_psel", bus.psel, 1'b0);
    checkOutput("ra_penable", bus.penable, 1'b0);
    checkOutput("ra_paddr", bus.paddr, 32'h0);
    checkOutput("ra_rdata", rspRdata, 32'h0);
    checkOutput("ra_err", rspErr, 1'b0);
    applyStimulus(3, 1'b1, 32'h0C, 1'b0, 32'h0, 4'h0);
    nextCycle();
    checkOutput("ra_no_done", done, 4'b0000);
    numWs   = 0;
    presetn = 1'b1;
    nextCycle();
    checkOutput("ra_restart_gnt", gnt, 4'b0100);
    nextCycle();
    nextCycle();
    checkOutput("ra_done2", done, 4'b0100);
    checkOutput("ra_rdata2", rspRdata, 32'hDEAD_BEEF);
    checkOutput("ra_gnt3", gnt, 4'b1000);
    req[2] = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("ra_done3", done, 4'b1000);
    checkOutput("ra_rdata3", rspRdata, 32'h3333_4444);
    req[3] = 1'b0;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
